// File: rtl/ram.sv
// Word-addressed RAM with four independently enabled byte lanes on bidirectional buses.
// Reads drive a lane combinationally; writes and the full clear happen on the clock edge.
module ram #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rw,
  input  logic        en1h,
  inout  wire  [7:0]  data1h,
  input  logic        en1l,
  inout  wire  [7:0]  data1l,
  input  logic        en2h,
  inout  wire  [7:0]  data2h,
  input  logic        en2l,
  inout  wire  [7:0]  data2l
);

  // Lane index 3 is the most significant byte (1h), lane 0 the least (2l).
  logic [3:0]       lane_en;
  logic [3:0]       lane_drive;
  logic [7:0]       wr_byte [4];
  logic [7:0]       rd_byte [4];
  logic [IDX_W-1:0] idx;
  logic             unused_addr;

  assign lane_en     = {en1h, en1l, en2h, en2l};
  assign idx         = addr[IDX_W-1:0];
  assign unused_addr = ^addr[31:IDX_W];

  assign wr_byte[3] = data1h;
  assign wr_byte[2] = data1l;
  assign wr_byte[1] = data2h;
  assign wr_byte[0] = data2l;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem_reg [DEPTH];

      // Reset clears every word and takes priority over a coincident write.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            lane_mem_reg[i] <= 8'h00;
          end
        end else if (rw && lane_en[gi]) begin
          lane_mem_reg[idx] <= wr_byte[gi];
        end
      end

      assign rd_byte[gi]    = lane_mem_reg[idx];
      assign lane_drive[gi] = lane_en[gi] & ~rw;
    end
  endgenerate

  assign data1h = lane_drive[3] ? rd_byte[3] : 8'bz;
  assign data1l = lane_drive[2] ? rd_byte[2] : 8'bz;
  assign data2h = lane_drive[1] ? rd_byte[1] : 8'bz;
  assign data2l = lane_drive[0] ? rd_byte[0] : 8'bz;

endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: byte-lane writes, combinational reads, reset clear, wrap and float.
// Buses are pulled up, so an undriven lane reads back as 8'hFF.
module tb_ram;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        rw;
  logic        en1h, en1l, en2h, en2l;
  logic        drv_en;
  logic [7:0]  drv1h, drv1l, drv2h, drv2l;
  tri1  [7:0]  d1h, d1l, d2h, d2l;
  int          checks;
  int          errors;
  logic [31:0] obs;

  assign d1h = drv_en ? drv1h : 8'bz;
  assign d1l = drv_en ? drv1l : 8'bz;
  assign d2h = drv_en ? drv2h : 8'bz;
  assign d2l = drv_en ? drv2l : 8'bz;

  ram #(.DEPTH(256), .IDX_W(8)) dut (
    .clock (clk),
    .reset (reset),
    .addr  (addr),
    .rw    (rw),
    .en1h  (en1h),
    .data1h(d1h),
    .en1l  (en1l),
    .data1l(d1l),
    .en2h  (en2h),
    .data2h(d2h),
    .en2l  (en2l),
    .data2l(d2l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rw = 1'b0;
    {en1h, en1l, en2h, en2l} = 4'b0000;
    drv_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] en, input logic [31:0] w);
    @(negedge clk);
    addr = a;
    rw = 1'b1;
    {en1h, en1l, en2h, en2l} = en;
    {drv1h, drv1l, drv2h, drv2l} = w;
    drv_en = 1'b1;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] en);
    @(negedge clk);
    addr = a;
    rw = 1'b0;
    {en1h, en1l, en2h, en2l} = en;
    drv_en = 1'b0;
    #1;
    obs = {d1h, d1l, d2h, d2l};
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(32'd7, 4'b1111);
    checks++;
    if (obs !== 32'h0000_0000) begin
      $display("FAIL reset_read addr=7 got=%h want=%h", obs, 32'h0);
      errors++;
    end
    $display("reset: read addr 7 -> %h", obs);
  endtask

  task automatic test_write_read();
    wr(32'd0, 4'b1111, {8'd240, 8'd153, 8'd129, 8'd15});
    rd(32'd0, 4'b1111);
    checks++;
    if (obs !== {8'd240, 8'd153, 8'd129, 8'd15}) begin
      $display("FAIL write_read addr=0 got=%h want=%h", obs, {8'd240, 8'd153, 8'd129, 8'd15});
      errors++;
    end
    $display("write_read: addr 0 -> %h", obs);
  endtask

  task automatic test_reset_clears();
    logic [31:0] al [3];
    al = '{32'd0, 32'd10, 32'd255};
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    foreach (al[i]) begin
      rd(al[i], 4'b1111);
      checks++;
      if (obs !== 32'h0) begin
        $display("FAIL reset_clear addr=%0d got=%h want=%h", al[i], obs, 32'h0);
        errors++;
      end
      $display("reset_clear: addr %0d -> %h", al[i], obs);
    end
  endtask

  task automatic test_multi_addr();
    logic [31:0] al [3];
    logic [31:0] exp [3];
    al  = '{32'd0, 32'd10, 32'd255};
    exp = '{32'h0000_0000, 32'h0101_0101, {8'd0, 8'd2, 8'd0, 8'd154}};
    wr(32'd10, 4'b1111, 32'h0101_0101);
    wr(32'd255, 4'b1111, {8'd0, 8'd2, 8'd0, 8'd154});
    foreach (al[i]) begin
      rd(al[i], 4'b1111);
      checks++;
      if (obs !== exp[i]) begin
        $display("FAIL multi_addr addr=%0d got=%h want=%h", al[i], obs, exp[i]);
        errors++;
      end
      $display("multi_addr: addr %0d -> %h", al[i], obs);
    end
    // Partial read: only 1h and 2h driven, the other lanes float high.
    rd(32'd255, 4'b1010);
    checks++;
    if (obs !== 32'h00FF_00FF) begin
      $display("FAIL partial_read addr=255 got=%h want=%h", obs, 32'h00FF_00FF);
      errors++;
    end
    $display("partial_read: addr 255 en=1010 -> %h", obs);
  endtask

  task automatic test_byte_lane();
    wr(32'd5, 4'b1111, 32'hFFFF_FFFF);
    wr(32'd5, 4'b0001, 32'h1234_5600);
    rd(32'd5, 4'b1111);
    checks++;
    if (obs !== 32'hFFFF_FF00) begin
      $display("FAIL byte_lane addr=5 got=%h want=%h", obs, 32'hFFFF_FF00);
      errors++;
    end
    $display("byte_lane: addr 5 -> %h", obs);
  endtask

  task automatic test_wrap_and_float();
    wr(32'd256, 4'b1111, 32'hAAAA_AAAA);
    rd(32'd0, 4'b1111);
    checks++;
    if (obs !== 32'hAAAA_AAAA) begin
      $display("FAIL wrap addr=0 got=%h want=%h", obs, 32'hAAAA_AAAA);
      errors++;
    end
    $display("wrap: addr 0 after write to 256 -> %h", obs);
    rd(32'h0001_0100, 4'b1111);
    checks++;
    if (obs !== 32'hAAAA_AAAA) begin
      $display("FAIL wrap_hi addr=%h got=%h want=%h", 32'h0001_0100, obs, 32'hAAAA_AAAA);
      errors++;
    end
    $display("wrap_hi: addr 0x10100 -> %h", obs);
    rd(32'd0, 4'b0000);
    checks++;
    if (obs !== 32'hFFFF_FFFF) begin
      $display("FAIL float_en0 addr=0 got=%h want=%h", obs, 32'hFFFF_FFFF);
      errors++;
    end
    $display("float_en0: addr 0 -> %h", obs);
    // rw=1 with no bench driver and no enables: nothing written, nothing driven.
    @(negedge clk);
    addr = 32'd0;
    rw = 1'b1;
    {en1h, en1l, en2h, en2l} = 4'b0000;
    drv_en = 1'b0;
    #1;
    obs = {d1h, d1l, d2h, d2l};
    checks++;
    if (obs !== 32'hFFFF_FFFF) begin
      $display("FAIL float_rw1_en0 addr=0 got=%h want=%h", obs, 32'hFFFF_FFFF);
      errors++;
    end
    $display("float_rw1_en0: addr 0 -> %h", obs);
    // rw=1 with enables set but bench not driving: lanes must still float.
    {en1h, en1l, en2h, en2l} = 4'b1111;
    #1;
    obs = {d1h, d1l, d2h, d2l};
    checks++;
    if (obs !== 32'hFFFF_FFFF) begin
      $display("FAIL float_rw1 addr=0 got=%h want=%h", obs, 32'hFFFF_FFFF);
      errors++;
    end
    $display("float_rw1: addr 0 -> %h", obs);
    idle();
    rd(32'd0, 4'b1111);
    checks++;
    if (obs !== 32'hAAAA_AAAA) begin
      $display("FAIL no_write_en0 addr=0 got=%h want=%h", obs, 32'hAAAA_AAAA);
      errors++;
    end
    $display("no_write_en0: addr 0 -> %h", obs);
  endtask

  task automatic test_addr_change();
    wr(32'd20, 4'b1111, 32'h0102_0304);
    wr(32'd21, 4'b1111, 32'hA1A2_A3A4);
    rd(32'd20, 4'b1111);
    addr = 32'd21;
    #1;
    obs = {d1h, d1l, d2h, d2l};
    checks++;
    if (obs !== 32'hA1A2_A3A4) begin
      $display("FAIL addr_change addr=21 got=%h want=%h", obs, 32'hA1A2_A3A4);
      errors++;
    end
    $display("addr_change: addr 20->21 -> %h", obs);
    addr = 32'd20;
    #1;
    obs = {d1h, d1l, d2h, d2l};
    checks++;
    if (obs !== 32'h0102_0304) begin
      $display("FAIL addr_change addr=20 got=%h want=%h", obs, 32'h0102_0304);
      errors++;
    end
    $display("addr_change: addr 21->20 -> %h", obs);
  endtask

  task automatic test_reset_write_collision();
    wr(32'd3, 4'b1111, 32'h1122_3344);
    @(negedge clk);
    addr = 32'd3;
    rw = 1'b1;
    {en1h, en1l, en2h, en2l} = 4'b1111;
    {drv1h, drv1l, drv2h, drv2l} = 32'h5555_5555;
    drv_en = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    rd(32'd3, 4'b1111);
    checks++;
    if (obs !== 32'h0) begin
      $display("FAIL reset_write addr=3 got=%h want=%h", obs, 32'h0);
      errors++;
    end
    $display("reset_write: addr 3 -> %h", obs);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    addr = 32'd0;
    {drv1h, drv1l, drv2h, drv2l} = 32'h0;
    idle();
    test_reset();
    test_write_read();
    test_reset_clears();
    test_multi_addr();
    test_byte_lane();
    test_wrap_and_float();
    test_addr_change();
    test_reset_write_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
